// File: rtl/uart_rx_fifo.sv
// 8N1 serial receiver feeding a show-ahead receive FIFO.
// Framing errors and FIFO overruns are reported as one-cycle status pulses.
module uart_rx_fifo #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FIFO_DEPTH   = 4,
    localparam int unsigned CW          = $clog2(FIFO_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rx_i,
    input  logic          rd_en,
    output logic [7:0]    rd_data,
    output logic          rd_valid,
    output logic [CW-1:0] count,
    output logic          frame_err,
    output logic          overrun
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] HALF_M1 = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] FULL_M1 = TW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

    state_e          state_q, state_d;
    logic            sync1_q, sync1_d;
    logic            rx_s_q, rx_s_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            err_wait_q, err_wait_d;
    logic            frame_err_q, frame_err_d;
    logic            overrun_q, overrun_d;
    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [7:0]      mem_d [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            rd_valid_q, rd_valid_d;
    logic [7:0]      rd_data_q, rd_data_d;
    logic            push_c;
    logic            pop_c;
    logic            full_c;
    logic            do_push_c;

    // Receiver: synchronizer, bit timing and framing
    always_comb begin
        state_d     = state_q;
        sync1_d     = rx_i;
        rx_s_d      = sync1_q;
        timer_d     = timer_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        err_wait_d  = err_wait_q;
        frame_err_d = 1'b0;
        push_c      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!rx_s_q) begin
                    timer_d = HALF_M1;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (timer_q == '0) begin
                    if (!rx_s_q) begin
                        timer_d   = FULL_M1;
                        bit_idx_d = 3'd0;
                        state_d   = S_DATA;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            S_DATA: begin
                if (timer_q == '0) begin
                    shift_d = {rx_s_q, shift_q[7:1]};
                    timer_d = FULL_M1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            S_STOP: begin
                // After a framing error, hold here until the line returns high
                if (err_wait_q) begin
                    if (rx_s_q) begin
                        err_wait_d = 1'b0;
                        state_d    = S_IDLE;
                    end
                end else if (timer_q == '0) begin
                    if (rx_s_q) begin
                        push_c  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        err_wait_d  = 1'b1;
                    end
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FIFO: a simultaneous pop frees the slot, so push on full is accepted then
    always_comb begin
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        overrun_d = 1'b0;
        pop_c     = rd_en && (count_q != '0);
        full_c    = (count_q == CW'(FIFO_DEPTH));
        do_push_c = push_c && (!full_c || pop_c);
        if (do_push_c) begin
            mem_d[wr_ptr_q] = shift_q;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (push_c && full_c && !pop_c) begin
            overrun_d = 1'b1;
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (do_push_c && !pop_c) begin
            count_d = count_q + CW'(1);
        end else if (!do_push_c && pop_c) begin
            count_d = count_q - CW'(1);
        end
        rd_valid_d = (count_d != '0);
        rd_data_d  = mem_d[rd_ptr_d];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            sync1_q     <= 1'b1;
            rx_s_q      <= 1'b1;
            timer_q     <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            err_wait_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= sync1_d;
            rx_s_q      <= rx_s_d;
            timer_q     <= timer_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            err_wait_q  <= err_wait_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
        end
    end

    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign count     = count_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: drives 8N1 frames and checks FIFO contents and status pulses.
module tb_uart_rx_fifo;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_i;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic [2:0] count;
    logic       frame_err;
    logic       overrun;

    int checks   = 0;
    int failures = 0;
    int fe_cnt   = 0;
    int ov_cnt   = 0;
    int fe0;
    int ov0;

    uart_rx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_i      (rx_i),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .count     (count),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (frame_err) fe_cnt++;
        if (overrun) ov_cnt++;
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            rx_i = 1'b1;
        end
    endtask

    // One frame on the line; optional long-low stop, pop on the stop-sample edge, or mid-frame reset
    task automatic send_byte(input logic [7:0] b, input int stop_low, input bit pop_at_stop,
                             input int rst_at);
        int k;
        for (int c = 0; c < (10 + stop_low) * CPB; c++) begin
            @(negedge clk);
            if (rst_at >= 0 && c == rst_at + 1) begin
                check("rst_mid count", count, 0);
                check("rst_mid valid", rd_valid, 0);
                check("rst_mid data", rd_data, 0);
            end
            k = c / CPB;
            if (k == 0) rx_i = 1'b0;
            else if (k <= 8) rx_i = b[k-1];
            else rx_i = ((k - 9) < stop_low) ? 1'b0 : 1'b1;
            rd_en = pop_at_stop && (c == 154);
            rst   = (c == rst_at);
        end
        rd_en = 1'b0;
        rst   = 1'b0;
    endtask

    task automatic pop_expect(input string tag, input logic [7:0] exp);
        @(negedge clk);
        check({tag, " valid"}, rd_valid, 1);
        check({tag, " data"}, rd_data, exp);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        rx_i  = 1'b1;
        rd_en = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset count", count, 0);
        check("reset valid", rd_valid, 0);
        check("reset data", rd_data, 0);
        check("reset frame_err", frame_err, 0);
        check("reset overrun", overrun, 0);
        idle(5);

        // Single byte
        send_byte(8'hA5, 0, 1'b0, -1);
        check("single count", count, 1);
        pop_expect("single", 8'hA5);
        check("single after pop valid", rd_valid, 0);
        check("single after pop count", count, 0);

        // Back-to-back ordering
        fe0 = fe_cnt; ov0 = ov_cnt;
        send_byte(8'h01, 0, 1'b0, -1);
        send_byte(8'h80, 0, 1'b0, -1);
        send_byte(8'hFF, 0, 1'b0, -1);
        send_byte(8'h00, 0, 1'b0, -1);
        check("b2b count", count, 4);
        pop_expect("b2b0", 8'h01);
        pop_expect("b2b1", 8'h80);
        pop_expect("b2b2", 8'hFF);
        pop_expect("b2b3", 8'h00);
        check("b2b fe pulses", fe_cnt - fe0, 0);
        check("b2b ov pulses", ov_cnt - ov0, 0);

        // Overrun, then full with simultaneous pop
        ov0 = ov_cnt;
        for (int i = 0; i < 5; i++) send_byte(8'(8'h10 + i), 0, 1'b0, -1);
        check("ovr pulses", ov_cnt - ov0, 1);
        check("ovr count", count, 4);
        for (int i = 0; i < 4; i++) pop_expect("ovr pop", 8'(8'h10 + i));
        check("ovr drained", count, 0);
        for (int i = 0; i < 4; i++) send_byte(8'(8'h20 + i), 0, 1'b0, -1);
        ov0 = ov_cnt;
        send_byte(8'h24, 0, 1'b1, -1);
        check("full+pop ov pulses", ov_cnt - ov0, 0);
        check("full+pop count", count, 4);
        for (int i = 1; i < 5; i++) pop_expect("full+pop", 8'(8'h20 + i));

        // Frame error then clean frame
        fe0 = fe_cnt;
        send_byte(8'h3C, 2, 1'b0, -1);
        idle(20);
        check("ferr pulses", fe_cnt - fe0, 1);
        check("ferr count", count, 0);
        send_byte(8'h55, 0, 1'b0, -1);
        check("after ferr count", count, 1);
        pop_expect("after ferr", 8'h55);

        // Short glitch
        fe0 = fe_cnt; ov0 = ov_cnt;
        repeat (4) begin
            @(negedge clk);
            rx_i = 1'b0;
        end
        idle(40);
        check("glitch count", count, 0);
        check("glitch fe", fe_cnt - fe0, 0);
        check("glitch ov", ov_cnt - ov0, 0);

        // Reset during data bit 4 with two bytes stored
        send_byte(8'h11, 0, 1'b0, -1);
        send_byte(8'h22, 0, 1'b0, -1);
        check("pre-rst count", count, 2);
        send_byte(8'hF0, 0, 1'b0, 88);
        idle(20);
        check("post-rst count", count, 0);
        check("post-rst valid", rd_valid, 0);
        send_byte(8'hC3, 0, 1'b0, -1);
        check("post-rst C3 count", count, 1);
        pop_expect("post-rst", 8'hC3);

        // Pop while empty
        repeat (10) begin
            @(negedge clk);
            rd_en = 1'b1;
        end
        @(negedge clk);
        rd_en = 1'b0;
        check("empty pop count", count, 0);
        check("empty pop valid", rd_valid, 0);
        send_byte(8'h7E, 0, 1'b0, -1);
        check("after empty pop count", count, 1);
        pop_expect("after empty pop", 8'h7E);
        check("final count", count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
